// File: rtl/sbox_rr_arbiter.sv
// sbox_rr_arbiter: one shared sbox9 behind a round-robin, valid/ready front end.
// Holds each result in a registered response slot tagged with the requester ID.
//
// sbox9 ports:
//   x_i        in   9      operand
//   y_o        out  9      substituted value
//
// sbox_rr_arbiter ports:
//   clk        in   1           rising-edge clock
//   rst_n      in   1           asynchronous reset, active low
//   req_valid  in   NREQ        per-requester request valid
//   req_ready  out  NREQ        per-requester accept, one-hot or zero
//   req_data   in   NREQ*WIDTH  operand of requester i at [i*WIDTH +: WIDTH]
//   rsp_valid  out  1           response slot holds a result
//   rsp_ready  in   1           consumer takes the response
//   rsp_data   out  WIDTH       sbox9 of the accepted operand
//   rsp_id     out  IDW         index of the requester served
//   served_cnt out  CNTW        accepted lookups, wraps at 2**CNTW

module sbox9 (
   input  logic [8:0] x_i,
   output logic [8:0] y_o
);

   // Power map y = x^5 in GF(2^9) modulo x^9 + x^4 + 1, then an affine XOR.
   // gcd(5, 511) = 1, so the map is a bijection on all 512 inputs.
   localparam logic [8:0] RED = 9'h011;
   localparam logic [8:0] AFF = 9'h0A5;

   function automatic logic [8:0] gf_mul(
      input logic [8:0] a,
      input logic [8:0] b
   );
      logic [8:0] p;
      logic [8:0] s;
      p = '0;
      s = a;
      for (int i = 0; i < 9; i++) begin
         if (b[i]) p = p ^ s;
         s = {s[7:0], 1'b0} ^ (s[8] ? RED : 9'h000);
      end
      return p;
   endfunction

   logic [8:0] x2;
   logic [8:0] x4;
   logic [8:0] x5;

   always_comb begin
      x2  = gf_mul(x_i, x_i);
      x4  = gf_mul(x2, x2);
      x5  = gf_mul(x4, x_i);
      y_o = x5 ^ AFF;
   end

endmodule

module sbox_rr_arbiter #(
   parameter int WIDTH = 9,
   parameter int NREQ  = 4,
   parameter int IDW   = 2,
   parameter int CNTW  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WIDTH-1:0]      rsp_data,
   output logic [IDW-1:0]        rsp_id,
   output logic [CNTW-1:0]       served_cnt
);

   localparam logic ST_EMPTY = 1'b0;
   localparam logic ST_FULL  = 1'b1;
   localparam int   PW       = IDW + 1;

   logic             state_q,  state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [WIDTH-1:0] data_q,   data_d;
   logic [IDW-1:0]   id_q,     id_d;
   logic [CNTW-1:0]  cnt_q,    cnt_d;

   logic             found;
   logic [IDW-1:0]   gnt;
   logic [PW-1:0]    idx;
   logic             can_accept;
   logic             accept;
   logic [WIDTH-1:0] operand;
   logic [WIDTH-1:0] sbox_y;

   // Rotating priority search from rr_ptr. The index is one bit wider
   // than an ID so the wrap at NREQ works for non-power-of-two NREQ.
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, rr_ptr_q} + PW'(k);
         if (idx >= PW'(NREQ)) idx = idx - PW'(NREQ);
         if (!found && req_valid[idx[IDW-1:0]]) begin
            found = 1'b1;
            gnt   = idx[IDW-1:0];
         end
      end
   end

   // rst_n gates acceptance so nothing is handed out during reset.
   assign can_accept = (state_q == ST_EMPTY) | rsp_ready;
   assign accept     = rst_n & found & can_accept;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[gnt] = 1'b1;
   end

   // The only path from req_data: the operand mux into the one S-box.
   always_comb begin
      operand = req_data[int'(gnt)*WIDTH +: WIDTH];
   end

   sbox9 u_sbox (
      .x_i (operand),
      .y_o (sbox_y)
   );

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      data_d   = data_q;
      id_d     = id_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         ST_EMPTY: begin
            if (accept) state_d = ST_FULL;
         end
         ST_FULL: begin
            if (rsp_ready && !accept) state_d = ST_EMPTY;
         end
         default: state_d = ST_EMPTY;
      endcase
      if (accept) begin
         data_d = sbox_y;
         id_d   = gnt;
         cnt_d  = cnt_q + 1'b1;
         if (gnt == IDW'(NREQ - 1)) rr_ptr_d = '0;
         else                       rr_ptr_d = gnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_EMPTY;
         rr_ptr_q <= '0;
         data_q   <= '0;
         id_q     <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         data_q   <= data_d;
         id_q     <= id_d;
         cnt_q    <= cnt_d;
      end
   end

   assign rsp_valid  = (state_q == ST_FULL);
   assign rsp_data   = data_q;
   assign rsp_id     = id_q;
   assign served_cnt = cnt_q;

endmodule

// File: tb/tb_sbox_rr_arbiter.sv
// tb_sbox_rr_arbiter: directed and random stimulus for sbox_rr_arbiter.
// Reference model uses a GF(2^9) log/antilog table and round-robin rules.

module tb_sbox_rr_arbiter;

   localparam int W  = 9;
   localparam int N  = 4;
   localparam int IW = 2;
   localparam int CW = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*W-1:0]  req_data;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [W-1:0]    rsp_data;
   logic [IW-1:0]   rsp_id;
   logic [CW-1:0]   served_cnt;

   sbox_rr_arbiter #(
      .WIDTH (W),
      .NREQ  (N),
      .IDW   (IW),
      .CNTW  (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_data   (req_data),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_id     (rsp_id),
      .served_cnt (served_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // S-box golden table: x^5 via discrete logs over alpha, XOR 0x0A5.
   logic [8:0] gtab [512];
   int ex [511];
   int lg [512];

   task automatic build_gtab();
      int e;
      e = 1;
      for (int i = 0; i < 511; i++) begin
         ex[i] = e;
         lg[e] = i;
         e = e << 1;
         if ((e & 512) != 0) e = e ^ 'h211;
      end
      gtab[0] = 9'h0A5;
      for (int x = 1; x < 512; x++)
         gtab[x] = 9'(ex[(5 * lg[x]) % 511]) ^ 9'h0A5;
   endtask

   // Model state
   bit         m_valid;
   logic [8:0] m_data;
   int         m_id;
   int         m_ptr;
   logic [15:0] m_cnt;

   // Requester side
   bit         pend  [N];
   logic [8:0] pdata [N];

   task automatic model_reset();
      m_valid = 0;
      m_data  = '0;
      m_id    = 0;
      m_ptr   = 0;
      m_cnt   = '0;
   endtask

   function automatic int winner();
      for (int k = 0; k < N; k++)
         if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   // Called just after a rising edge; returns just after the next one.
   task automatic step();
      int  w;
      bit  can;
      logic [N-1:0] er;
      for (int i = 0; i < N; i++) begin
         req_valid[i]        = pend[i];
         req_data[i*W +: W]  = pdata[i];
      end
      @(negedge clk);
      w   = winner();
      can = !m_valid || rsp_ready;
      er  = '0;
      if (w >= 0 && can) er[w] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid) begin
         chk("rsp_data", 32'(rsp_data), 32'(m_data));
         chk("rsp_id", 32'(rsp_id), 32'(m_id));
      end
      chk("served_cnt", 32'(served_cnt), 32'(m_cnt));
      @(posedge clk);
      if (w >= 0 && can) begin
         m_data  = gtab[pdata[w]];
         m_id    = w;
         m_valid = 1;
         m_ptr   = (w + 1) % N;
         m_cnt   = m_cnt + 16'd1;
         pend[w] = 0;
      end else if (rsp_ready) begin
         m_valid = 0;
      end
      #1;
   endtask

   task automatic reset_dut();
      for (int i = 0; i < N; i++) pend[i] = 0;
      req_valid = '0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int x;
      int cyc;
      build_gtab();
      for (int i = 0; i < N; i++) begin
         pend[i]  = 0;
         pdata[i] = '0;
      end
      rsp_ready = 1'b1;
      req_data  = '0;
      req_valid = 4'b0001;
      rst_n     = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_valid", 32'(rsp_valid), 0);
      chk("rst_data", 32'(rsp_data), 0);
      chk("rst_id", 32'(rsp_id), 0);
      chk("rst_cnt", 32'(served_cnt), 0);
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single request
      pend[0] = 1; pdata[0] = 9'h000;
      step();
      chk("single_data", 32'(rsp_data), 32'(gtab[0]));
      chk("single_id", 32'(rsp_id), 0);
      chk("single_cnt", 32'(served_cnt), 1);
      step();

      // All four valid, back to back
      reset_dut();
      for (int i = 0; i < N; i++) begin
         pend[i] = 1; pdata[i] = 9'(9'h100 + i);
      end
      for (int c = 0; c < N; c++) begin
         step();
         chk("all_id", 32'(rsp_id), 32'(c));
         chk("all_data", 32'(rsp_data), 32'(gtab[9'h100 + c]));
      end
      chk("all_cnt", 32'(served_cnt), 4);
      step();

      // Backpressure
      reset_dut();
      for (int i = 0; i < N; i++) begin
         pend[i] = 1; pdata[i] = 9'(9'h100 + i);
      end
      step();
      rsp_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("bp_data", 32'(rsp_data), 32'(gtab[9'h100]));
         chk("bp_id", 32'(rsp_id), 0);
         chk("bp_cnt", 32'(served_cnt), 1);
      end
      rsp_ready = 1'b1;
      step();
      chk("bp_resume_id", 32'(rsp_id), 1);
      repeat (4) step();

      // Fairness: 0 and 2 always valid
      reset_dut();
      for (int c = 0; c < 10; c++) begin
         if (!pend[0]) begin pend[0] = 1; pdata[0] = 9'($urandom); end
         if (!pend[2]) begin pend[2] = 1; pdata[2] = 9'($urandom); end
         step();
         chk("fair_id", 32'(rsp_id), (c % 2) ? 2 : 0);
      end

      // Reset mid-operation with a held response
      reset_dut();
      for (int i = 0; i < N; i++) begin
         pend[i] = 1; pdata[i] = 9'($urandom);
      end
      step();
      rsp_ready = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      chk("mid_valid", 32'(rsp_valid), 0);
      chk("mid_cnt", 32'(served_cnt), 0);
      chk("mid_ready", 32'(req_ready), 0);
      model_reset();
      for (int i = 0; i < N; i++) pend[i] = 0;
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      pend[0] = 1; pdata[0] = 9'h055;
      pend[3] = 1; pdata[3] = 9'h1AA;
      step();
      chk("mid_first_id", 32'(rsp_id), 0);
      step();
      step();

      // Exhaustive sweep through requester 3
      reset_dut();
      x = 0;
      cyc = 0;
      while ((x < 512 || pend[3]) && cyc < 6000) begin
         if (!pend[3] && x < 512) begin
            pend[3] = 1; pdata[3] = 9'(x); x++;
         end
         rsp_ready = ($urandom_range(0, 99) < 60);
         step();
         cyc++;
      end
      chk("sweep_done", 32'(x + (pend[3] ? 1 : 0)), 512);
      rsp_ready = 1'b1;
      step();
      step();
      chk("sweep_cnt", 32'(served_cnt), 512);

      // Random traffic
      reset_dut();
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 99) < 40) begin
               pend[i] = 1; pdata[i] = 9'($urandom);
            end else if (pend[i] && $urandom_range(0, 99) < 4) begin
               pend[i] = 0;
            end
         end
         rsp_ready = ($urandom_range(0, 99) < 70);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
